// File: rtl/axis_decoupler_pkg.sv
// Shared definitions for the AXI-Stream master/slave decoupler pair.
package axis_decoupler_pkg;

  typedef enum logic [1:0] {
    ST_PASS      = 2'd0,
    ST_WAIT_EOP  = 2'd1,
    ST_TERM      = 2'd2,
    ST_DECOUPLED = 2'd3
  } dec_state_e;

  localparam int DEFAULT_BUS_WIDTH = 64;
  localparam int KEEP_WIDTH        = DEFAULT_BUS_WIDTH / 8;

  // tkeep width for an arbitrary tdata width (one strobe per byte).
  function automatic int keep_width(input int bus_width);
    return bus_width / 8;
  endfunction

endpackage

// File: rtl/axis_packet_tracker.sv
// Remembers whether a packet is open on one AXI-Stream interface:
// set by a handshake without tlast, cleared by a handshake with tlast.
module axis_packet_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  input  logic last,
  output logic outst,
  output logic outst_nxt
);

  logic outst_q;
  logic outst_d;

  assign outst_d   = (valid && ready) ? !last : outst_q;
  assign outst_nxt = outst_d;
  assign outst     = outst_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
    end
  end

endmodule

// File: rtl/axi_stream_master_decoupler.sv
// Isolates an untrusted AXI-Stream master from a trusted slave, either after the
// current packet (decouple) or immediately with a synthetic tlast beat (decouple_force).
module axi_stream_master_decoupler
  import axis_decoupler_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  localparam int KW             = keep_width(AXIS_BUS_WIDTH)
) (
  input  logic                       aclk,
  input  logic                       aresetn,

  input  logic [AXIS_BUS_WIDTH-1:0]  axis_s_tdata,
  input  logic [AXIS_DEST_WIDTH-1:0] axis_s_tdest,
  input  logic [KW-1:0]              axis_s_tkeep,
  input  logic                       axis_s_tlast,
  input  logic                       axis_s_tvalid,
  output logic                       axis_s_tready,

  output logic [AXIS_BUS_WIDTH-1:0]  axis_m_tdata,
  output logic [AXIS_DEST_WIDTH-1:0] axis_m_tdest,
  output logic [KW-1:0]              axis_m_tkeep,
  output logic                       axis_m_tlast,
  output logic                       axis_m_tvalid,
  input  logic                       axis_m_tready,

  input  logic                       decouple,
  input  logic                       decouple_force,
  output logic                       decouple_done,
  output logic                       decoupled,
  output logic                       packet_truncated
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  dec_state_e                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d, cnt_inc;
  logic [AXIS_DEST_WIDTH-1:0] dest_hold_q, dest_hold_d;

  logic m_tvalid_raw, s_tready_raw;
  logic m_hs, s_hs, stall, timeout_hit;
  logic m_outst, m_outst_nxt, s_outst, s_outst_nxt;

  axis_packet_tracker u_m_track (
    .clk       (aclk),
    .rst_n     (aresetn),
    .valid     (axis_m_tvalid),
    .ready     (axis_m_tready),
    .last      (axis_m_tlast),
    .outst     (m_outst),
    .outst_nxt (m_outst_nxt)
  );

  axis_packet_tracker u_s_track (
    .clk       (aclk),
    .rst_n     (aresetn),
    .valid     (axis_s_tvalid),
    .ready     (axis_s_tready),
    .last      (axis_s_tlast),
    .outst     (s_outst),
    .outst_nxt (s_outst_nxt)
  );

  // Only the look-ahead flags steer the FSM; the registered copies are kept for debug.
  logic unused_outst;
  assign unused_outst = &{1'b0, m_outst, s_outst};

  always_comb begin
    // NOTE: every combinational output gets a default first, so no case path infers a latch.
    axis_m_tdata = axis_s_tdata;
    axis_m_tdest = axis_s_tdest;
    axis_m_tkeep = axis_s_tkeep;
    axis_m_tlast = axis_s_tlast;
    m_tvalid_raw = axis_s_tvalid;
    s_tready_raw = axis_m_tready;
    case (state_q)
      ST_TERM: begin
        axis_m_tdata = '0;
        axis_m_tdest = dest_hold_q;
        axis_m_tkeep = '0;
        axis_m_tlast = 1'b1;
        m_tvalid_raw = 1'b1;
        s_tready_raw = 1'b1;
      end
      ST_DECOUPLED: begin
        m_tvalid_raw = 1'b0;
        s_tready_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Handshake qualifiers are forced low while reset is held, independent of state.
  assign axis_m_tvalid    = aresetn && m_tvalid_raw;
  assign axis_s_tready    = aresetn && s_tready_raw;
  assign decoupled        = aresetn && (state_q == ST_TERM || state_q == ST_DECOUPLED);
  assign decouple_done    = aresetn && (state_q == ST_DECOUPLED) && (decouple || decouple_force);
  assign packet_truncated = aresetn && (state_q == ST_TERM) && axis_m_tready;

  assign m_hs  = axis_m_tvalid && axis_m_tready;
  assign s_hs  = axis_s_tvalid && axis_s_tready;
  assign stall = axis_m_tvalid && !axis_m_tready;

  // Count includes the current cycle, so TERM follows exactly TIMEOUT_CYCLES waiting cycles.
  assign cnt_inc     = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CW'(1);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_inc == TO_VAL);
  assign cnt_d       = (state_q == ST_WAIT_EOP) ? cnt_inc : '0;
  assign dest_hold_d = m_hs ? axis_m_tdest : dest_hold_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: begin
        if (!stall) begin
          if (decouple_force) begin
            state_d = m_outst_nxt ? ST_TERM : ST_DECOUPLED;
          end else if (decouple) begin
            state_d = m_outst_nxt ? ST_WAIT_EOP : ST_DECOUPLED;
          end
        end
      end
      ST_WAIT_EOP: begin
        if (m_hs && axis_m_tlast) begin
          state_d = ST_DECOUPLED;
        end else if ((decouple_force || (decouple && timeout_hit)) && !stall) begin
          state_d = ST_TERM;
        end else if (!decouple && !decouple_force) begin
          state_d = ST_PASS;
        end
      end
      ST_TERM: begin
        if (axis_m_tready) state_d = ST_DECOUPLED;
      end
      ST_DECOUPLED: begin
        // Wait for the dropped packet's tlast so its tail never reaches the slave.
        if (!decouple && !decouple_force && !s_outst_nxt) state_d = ST_PASS;
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_PASS;
      cnt_q       <= '0;
      dest_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dest_hold_q <= dest_hold_d;
    end
  end

  logic unused_hs;
  assign unused_hs = &{1'b0, s_hs};

endmodule

// File: doc/axi_stream_master_decoupler.md
AXI_STREAM_MASTER_DECOUPLER -- requirements
Module: axi_stream_master_decoupler

Interface
REQ-001 SHALL have parameter AXIS_BUS_WIDTH, default 64: tdata width in bits, multiple of 8.
REQ-002 SHALL have parameter AXIS_DEST_WIDTH, default 4: tdest width in bits, at least 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum passive-decouple wait; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: aclk  in  1  clock, all ports synchronous to it.
REQ-005 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 axis_s_tdata/tdest/tkeep/tlast/tvalid  in  AXIS_BUS_WIDTH/AXIS_DEST_WIDTH/AXIS_BUS_WIDTH/8/1/1  stream from the master being decoupled.
REQ-007 axis_s_tready  out  1  backpressure to that master.
REQ-008 axis_m_tdata/tdest/tkeep/tlast/tvalid  out  same widths as REQ-006  stream to the trusted downstream slave.
REQ-009 axis_m_tready  in  1  downstream backpressure.
REQ-010 decouple  in  1  passive request: finish the current packet, then decouple.
REQ-011 decouple_force  in  1  active request: terminate the current packet immediately.
REQ-012 decouple_done  out  1  decouple request satisfied.
REQ-013 decoupled  out  1  core is in TERM or DECOUPLED.
REQ-014 packet_truncated  out  1  one-cycle pulse when a synthetic terminating beat handshakes.

Function
REQ-015 SHALL implement an FSM with states PASS, WAIT_EOP, TERM and DECOUPLED.
REQ-016 PASS and WAIT_EOP SHALL pass the stream through combinationally: all axis_m_* = axis_s_*, and axis_s_tready = axis_m_tready.
REQ-017 SHALL track m_outst: set on an m-side handshake without tlast; cleared on an m-side handshake with tlast.
REQ-018 SHALL track s_outst the same way on s-side handshakes, in every state.
REQ-019 SHALL capture axis_m_tdest into dest_hold on every m-side handshake.
REQ-020 SHALL leave PASS only when no stalled beat is present, i.e. not (axis_m_tvalid and not axis_m_tready), so that AXI-Stream stability is never broken.
REQ-021 PASS with decouple_force: m_outst_nxt=1 -> TERM; otherwise -> DECOUPLED.
REQ-022 PASS with decouple: m_outst_nxt=1 -> WAIT_EOP; otherwise -> DECOUPLED. m_outst_nxt SHALL include the current-cycle handshake.
REQ-023 WAIT_EOP: a tlast handshake -> DECOUPLED.
REQ-024 WAIT_EOP: decouple_force, or the timeout counter reaching TIMEOUT_CYCLES with TIMEOUT_CYCLES>0 -> TERM, subject to REQ-020.
REQ-025 WAIT_EOP: decouple deasserted -> PASS.
REQ-026 The timeout counter SHALL count cycles spent in WAIT_EOP, be cleared on entry, and saturate.
REQ-027 TERM SHALL drive axis_m_tvalid=1, tlast=1, tkeep=0, tdata=0, tdest=dest_hold, and axis_s_tready=1 (input beats are dropped).
REQ-028 TERM SHALL hold its outputs until axis_m_tready, then move to DECOUPLED and pulse packet_truncated.
REQ-029 DECOUPLED SHALL drive axis_m_tvalid=0 and axis_s_tready=1 (all input beats dropped).
REQ-030 DECOUPLED -> PASS SHALL occur when decouple=0, decouple_force=0, and s_outst_nxt=0, so that the tail of a dropped packet is never forwarded.
REQ-031 While in DECOUPLED, axis_m_tdata/tkeep/tlast/tdest SHALL pass through and be ignored by the slave.
REQ-032 decouple_done SHALL equal (state==DECOUPLED) and (decouple or decouple_force).
REQ-033 If decouple and decouple_force are asserted together, force SHALL take precedence.

Reset
REQ-034 aresetn low SHALL asynchronously set state=PASS, m_outst=0, s_outst=0, counter=0, dest_hold=0.
REQ-035 While aresetn is low, axis_m_tvalid, axis_s_tready, decouple_done, decoupled and packet_truncated SHALL be 0.
REQ-036 A reset mid-packet SHALL abandon the packet with no synthetic beat generated.

Structure
REQ-037 The state enum and a KEEP_WIDTH helper constant SHALL live in package axis_decoupler_pkg, shared with the slave decoupler.
REQ-038 The tlast-tracking flag SHALL be a sub-module axis_packet_tracker (inputs valid, ready, last; outputs outst, outst_nxt), instantiated twice (s-side and m-side).

Verification
REQ-039 Idle stream, decouple=1 -> DECOUPLED next cycle; decouple_done=1; axis_m_tvalid=0 thereafter.
REQ-040 Decouple asserted after beat 2 of a 5-beat packet -> beats 3-5 forwarded, then DECOUPLED; packet_truncated stays 0.
REQ-041 decouple_force after beat 2 with axis_m_tready=0 for 3 cycles -> TERM beat with tlast=1, tkeep=0, tdest=the packet's tdest held stable 3 cycles, then packet_truncated pulses once.
REQ-042 TIMEOUT_CYCLES=8, decouple asserted mid-packet, master stalls -> TERM entered after 8 WAIT_EOP cycles.
REQ-043 Decouple released while the master is mid-packet -> remaining beats dropped (axis_s_tready=1); PASS resumes only after that packet's tlast; next packet forwarded intact.
REQ-044 aresetn pulsed low during TERM -> all outputs 0 immediately; PASS after release; no synthetic beat emitted.
